// File: rtl/spi32x2_pkg.sv
// Shared types and field positions for the two-frame 32-bit SPI status/control link.
package spi32x2_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD_LO, S_LOAD_HI, S_SHIFT_LO, S_SHIFT_HI, S_GAP, S_DONE
  } state_t;

  localparam int FRAME_BITS = 32;
  localparam int N_FRAMES   = 2;

  localparam int ALE1  = 0;
  localparam int ALE2  = 1;
  localparam int ALE3  = 2;
  localparam int ERROR = 3;
  localparam int UPR1  = 4;
  localparam int UPR2  = 5;
  localparam int GBR   = 7;

  localparam int STAT_MSB = 31;
  localparam int STAT_LSB = 27;
endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: pulses tick once every DIV enabled cycles; restart holds it at zero.
module spi_half_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && !restart && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt <= '0;
    else if (restart || !en || tick) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_32bx2_master.sv
// SPI initiator: per start, two 32-bit frames, each preceded by a cs-high load edge,
// reading a status word on miso while sending the same control word on mosi.
module spi_32bx2_master #(
  parameter int DIV = 4,
  parameter int GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word0,
  output logic [31:0] rx_word1,
  output logic [4:0]  status_flags,
  output logic        cs,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);
  import spi32x2_pkg::*;

  localparam int GW = $clog2(GAP + 1);

  state_t        state;
  logic [31:0]   tx_sh, tx_lat, rx_sh, hold0;
  logic [5:0]    bitc;
  logic [GW-1:0] gcnt;
  logic [1:0]    miso_sync;
  logic          frame, samp, tick, miso_s;

  assign miso_s = miso_sync[1];

  spi_half_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .restart (state == S_IDLE || state == S_GAP || state == S_DONE),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso_sync <= '0;
    else     miso_sync <= {miso_sync[0], miso};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cs           <= 1'b0;
      sck          <= 1'b1;
      mosi         <= 1'b0;
      tx_sh        <= '0;
      tx_lat       <= '0;
      rx_sh        <= '0;
      hold0        <= '0;
      rx_word0     <= '0;
      rx_word1     <= '0;
      status_flags <= '0;
      bitc         <= '0;
      gcnt         <= '0;
      frame        <= 1'b0;
      samp         <= 1'b0;
    end else begin
      done <= 1'b0;
      // miso is taken one clk into the high phase so the synchroniser delay fits when DIV>=2
      if (samp) begin
        rx_sh <= {rx_sh[30:0], miso_s};
        samp  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            tx_sh  <= tx_word;
            tx_lat <= tx_word;
            frame  <= 1'b0;
            busy   <= 1'b1;
            cs     <= 1'b1;
            sck    <= 1'b1;
            mosi   <= 1'b0;
            state  <= S_SETUP;
          end
        end
        S_SETUP: if (tick) begin
          sck   <= 1'b0;
          state <= S_LOAD_LO;
        end
        S_LOAD_LO: if (tick) begin
          sck   <= 1'b1;
          cs    <= 1'b0;
          mosi  <= tx_sh[31];
          bitc  <= '0;
          state <= S_LOAD_HI;
        end
        S_LOAD_HI: if (tick) begin
          sck   <= 1'b0;
          state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: if (tick) begin
          sck   <= 1'b1;
          samp  <= 1'b1;
          tx_sh <= {tx_sh[30:0], 1'b0};
          mosi  <= tx_sh[30];
          bitc  <= bitc + 6'd1;
          state <= S_SHIFT_HI;
        end
        S_SHIFT_HI: if (tick) begin
          if (bitc == 6'(FRAME_BITS)) begin
            mosi  <= 1'b0;
            gcnt  <= '0;
            state <= S_GAP;
          end else begin
            sck   <= 1'b0;
            state <= S_SHIFT_LO;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1)) begin
            gcnt <= '0;
            // the frame-0 copy is taken at the end of the gap so a late DIV=1 sample is included
            if (!frame) begin
              hold0 <= rx_sh;
              frame <= 1'b1;
              tx_sh <= tx_lat;
              cs    <= 1'b1;
              state <= S_SETUP;
            end else begin
              state <= S_DONE;
            end
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_DONE: begin
          done         <= 1'b1;
          rx_word0     <= hold0;
          rx_word1     <= rx_sh;
          status_flags <= rx_sh[STAT_MSB:STAT_LSB];
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_32bx2_master.sv
// Bench for spi_32bx2_master: three instances (DIV=2,1,7) with responder models and a scoreboard.
`timescale 1ns/1ps
module tb_spi_32bx2_master;
  import spi32x2_pkg::*;

  localparam int NI   = 3;
  localparam int GAPV = 4;

  typedef struct {
    int          id;
    logic [31:0] rx0;
    logic [31:0] rx1;
    logic [31:0] ctl;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] start_v = '0;
  logic [NI-1:0] busy_v, done_v, cs_v, sck_v, mosi_v;
  logic [31:0]   tx_v [NI];
  logic [31:0]   rw   [NI][2];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [31:0] rx0, rx1;
    logic [31:0] sh = '0, rcv0 = '0, rcv1 = '0;
    logic [4:0]  fl;
    logic        m = 1'b0, clr = 1'b0, pdone = 1'b0, pcs = 1'b0;
    int          lcnt = 0, s0 = 0, s1 = 0, vio = 0, dcnt = 0;
    time         t0 = 0;
    exp_t        e;

    spi_32bx2_master #(.DIV(D), .GAP(GAPV)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .tx_word(tx_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .rx_word0(rx0), .rx_word1(rx1),
      .status_flags(fl), .cs(cs_v[g]), .sck(sck_v[g]), .mosi(mosi_v[g]), .miso(m)
    );

    // responder: load on a cs-high falling edge, shift out/in on cs-low falling edges
    always @(negedge sck_v[g] or posedge rst or posedge clr) begin
      if (rst || clr) begin
        lcnt <= 0; s0 <= 0; s1 <= 0; m <= 1'b0;
      end else if (cs_v[g]) begin
        sh   <= rw[g][lcnt % 2];
        m    <= 1'b0;
        lcnt <= lcnt + 1;
      end else begin
        m  <= sh[31];
        sh <= {sh[30:0], mosi_v[g]};
        if (lcnt == 1) begin
          s0 <= s0 + 1;
          if (s0 == 31) rcv0 <= {sh[30:0], mosi_v[g]};
        end else begin
          s1 <= s1 + 1;
          if (s1 == 31) rcv1 <= {sh[30:0], mosi_v[g]};
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (start_v[g] && !busy_v[g]) begin
          t0  <= $time;
          clr <= 1'b1;
          vio <= 0;
        end else begin
          clr <= 1'b0;
          if (cs_v[g] !== pcs && sck_v[g] !== 1'b1) vio <= vio + 1;
        end
        if (done_v[g]) begin
          dcnt <= dcnt + 1;
          chk($sformatf("done_width%0d", g), pdone, 0);
          chk($sformatf("sb_nonempty%0d", g), sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("inst%0d", g), g, e.id);
            chk($sformatf("rx_word0_d%0d", D), rx0, e.rx0);
            chk($sformatf("rx_word1_d%0d", D), rx1, e.rx1);
            chk($sformatf("flags_d%0d", D), fl, e.fl);
            chk($sformatf("latency_d%0d", D), ($time - t0) / 10, e.lat);
            chk($sformatf("mosi_f0_d%0d", D), rcv0, e.ctl);
            chk($sformatf("mosi_f1_d%0d", D), rcv1, e.ctl);
            chk($sformatf("load_edges_d%0d", D), lcnt, 2);
            chk($sformatf("shift_edges_f0_d%0d", D), s0, 32);
            chk($sformatf("shift_edges_f1_d%0d", D), s1, 32);
            chk($sformatf("cs_while_sck_low_d%0d", D), vio, 0);
          end
        end
      end
      pcs   <= cs_v[g];
      pdone <= done_v[g];
    end
  end

  function automatic int lat_of(input int d);
    return 2 * (67 * d + GAPV) + 2;
  endfunction

  task automatic push(input int g, input int d, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] ctl);
    exp_t x;
    x.id  = g;
    // at DIV=1 the synchroniser delay makes every captured bit lag by one position
    x.rx0 = (d == 1) ? {1'b0, w0[31:1]} : w0;
    x.rx1 = (d == 1) ? {1'b0, w1[31:1]} : w1;
    x.ctl = ctl;
    x.fl  = x.rx1[STAT_MSB:STAT_LSB];
    x.lat = lat_of(d);
    sb.push_back(x);
  endtask

  task automatic kick(input int g, input logic [31:0] w);
    tx_v[g]    = w;
    start_v[g] = 1'b1;
    @(posedge clk); #1;
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done_v[g]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("done_timeout%0d", g), seen, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      tx_v[i] = '0; rw[i][0] = '0; rw[i][1] = '0;
    end
    repeat (3) @(posedge clk); #1;
    chk("rst_cs", cs_v, 0);
    chk("rst_sck", sck_v, 3'b111);
    chk("rst_mosi", mosi_v, 0);
    chk("rst_busy", busy_v, 0);
    chk("rst_done", done_v, 0);
    rst = 1'b0;

    // abort mid-shift: nothing pushed, so any done is caught by the monitor
    @(posedge clk); #1;
    rw[0][0] = 32'h1357_9BDF; rw[0][1] = 32'h2468_ACE0;
    kick(0, 32'h1234_5678);
    repeat (40) @(posedge clk); #1;
    chk("abort_busy_before", busy_v[0], 1);
    rst = 1'b1; #1;
    chk("abort_cs", cs_v[0], 0);
    chk("abort_sck", sck_v[0], 1);
    chk("abort_mosi", mosi_v[0], 0);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_rx0", g_i[0].rx0, 0);
    chk("abort_rx1", g_i[0].rx1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (400) @(posedge clk); #1;
    chk("abort_no_done", g_i[0].dcnt, 0);

    // basic transaction
    rw[0][0] = 32'hA5A5_1234; rw[0][1] = 32'h8000_00FF;
    push(0, 2, rw[0][0], rw[0][1], 32'h0000_00B5);
    kick(0, 32'h0000_00B5);
    wait_done(0, 400);
    chk("basic_flags_const", g_i[0].fl, 5'b10000);
    chk("ALE1", g_i[0].rcv1[ALE1], 1);
    chk("ALE2", g_i[0].rcv1[ALE2], 0);
    chk("ALE3", g_i[0].rcv1[ALE3], 1);
    chk("ERROR", g_i[0].rcv1[ERROR], 0);
    chk("upr1", g_i[0].rcv1[UPR1], 1);
    chk("upr2", g_i[0].rcv1[UPR2], 1);
    chk("GBR", g_i[0].rcv1[GBR], 1);
    @(posedge clk); #1;
    chk("busy_after_done", busy_v[0], 0);

    // idle reset clears captured words
    rst = 1'b1; #1;
    chk("idle_rst_rx0", g_i[0].rx0, 0);
    chk("idle_rst_rx1", g_i[0].rx1, 0);
    chk("idle_rst_flags", g_i[0].fl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // start held 3 cycles, then pulsed mid-transaction
    rw[0][0] = 32'hDEAD_BEEF; rw[0][1] = 32'h0F0F_0F0F;
    push(0, 2, rw[0][0], rw[0][1], 32'h5A5A_C33C);
    tx_v[0] = 32'h5A5A_C33C; start_v[0] = 1'b1;
    repeat (3) @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (50) @(posedge clk); #1;
    kick(0, 32'h1111_1111);
    wait_done(0, 400);
    repeat (300) @(posedge clk); #1;
    chk("single_txn_dcnt", g_i[0].dcnt, 2);

    // back-to-back: start raised in the done cycle is ignored, accepted the cycle after
    rw[0][0] = 32'h0000_0001; rw[0][1] = 32'hFFFF_FFFE;
    push(0, 2, rw[0][0], rw[0][1], 32'hFFFF_FFFF);
    kick(0, 32'hFFFF_FFFF);
    wait_done(0, 400);
    push(0, 2, rw[0][0], rw[0][1], 32'hFFFF_FFFF);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (5) @(posedge clk); #1;
    chk("b2b_dcnt", g_i[0].dcnt, 4);

    // timing sweep on the DIV=1 and DIV=7 instances
    rw[1][0] = 32'hC0FF_EE11; rw[1][1] = 32'h9ABC_DEF0;
    push(1, 1, rw[1][0], rw[1][1], 32'h0000_0077);
    $display("[TB] note: DIV=1 expects captured words lagging by one bit");
    kick(1, 32'h0000_0077);
    wait_done(1, 300);
    repeat (3) @(posedge clk); #1;
    rw[2][0] = 32'h7E57_0042; rw[2][1] = 32'hF800_1234;
    push(2, 7, rw[2][0], rw[2][1], 32'hCAFE_00A9);
    kick(2, 32'hCAFE_00A9);
    wait_done(2, 1200);
    repeat (3) @(posedge clk); #1;
    chk("sweep_d1_dcnt", g_i[1].dcnt, 1);
    chk("sweep_d7_dcnt", g_i[2].dcnt, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
